ray_march_ctrl: RTL

RAY_MARCH_CTRL -- requirements
Module: ray_march_ctrl

---
 rtl/ray_march_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ray_march_ctrl.sv
// Sphere-tracing sequencer: marches one ray through a sceneQuery distance oracle.
// Define RAY_MARCH_TIMEOUT_EN to build the 8-bit WAIT watchdog (res_timeout).
//
//   state | meaning
//   IDLE  | ray_ready high, waiting for a ray
//   STEP  | register pos = origin + dir*t
//   QUERY | query_valid pulse, steps++
//   WAIT  | waiting for dist_valid (or watchdog expiry)
//   DONE  | result held until res_ready
module ray_march_ctrl #(
  parameter int unsigned MAX_STEPS = 64,
  parameter logic [31:0] HIT_EPS   = 32'h00004000,
  parameter logic [31:0] MAX_DIST  = 32'h20000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ray_valid,
  output logic        ray_ready,
  input  logic [95:0] ray_origin,
  input  logic [95:0] ray_dir,
  input  logic [2:0]  ray_obj,
  output logic        query_valid,
  output logic [95:0] query_pos,
  output logic [2:0]  query_obj,
  input  logic [31:0] dist_in,
  input  logic        dist_valid,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_hit,
  output logic [95:0] res_pos,
  output logic [31:0] res_depth,
  output logic [7:0]  res_steps,
  output logic        res_timeout
);

  typedef enum logic [2:0] {IDLE, STEP, QUERY, WAIT, DONE} state_t;

  localparam logic [7:0]         STEP_LIMIT = 8'(MAX_STEPS);
  localparam logic signed [32:0] FAR_PLANE  = {MAX_DIST[31], MAX_DIST};

  state_t      state;
  logic [95:0] origin;
  logic [95:0] dir;
  logic [31:0] t;
  logic [7:0]  steps;

  logic signed [32:0] t_sum;
  logic               is_hit;
  logic               is_miss;

  // 33-bit sum so a wrap past +128.0 still compares as beyond the far plane
  always_comb begin
    t_sum   = $signed({t[31], t}) + $signed({dist_in[31], dist_in});
    is_hit  = $signed(dist_in) < $signed(HIT_EPS);
    is_miss = (steps == STEP_LIMIT) || (t_sum >= FAR_PLANE);
  end

  function automatic logic [31:0] march(input logic [31:0] o, input logic [31:0] d,
                                        input logic [31:0] tt);
    logic signed [63:0] p;
    p = $signed({{32{d[31]}}, d}) * $signed({{32{tt[31]}}, tt});
    return o + p[55:24];
  endfunction

`ifdef RAY_MARCH_TIMEOUT_EN
  logic [7:0] wd;
  logic       timeout_q;
  assign res_timeout = timeout_q;
`else
  assign res_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      ray_ready   <= 1'b0;
      origin      <= '0;
      dir         <= '0;
      t           <= '0;
      steps       <= '0;
      query_valid <= 1'b0;
      query_pos   <= '0;
      query_obj   <= '0;
      res_valid   <= 1'b0;
      res_hit     <= 1'b0;
      res_pos     <= '0;
      res_depth   <= '0;
      res_steps   <= '0;
`ifdef RAY_MARCH_TIMEOUT_EN
      wd          <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      query_valid <= 1'b0;
      case (state)
        IDLE: begin
          ray_ready <= 1'b1;
          if (ray_valid && ray_ready) begin
            origin    <= ray_origin;
            dir       <= ray_dir;
            query_obj <= ray_obj;
            t         <= '0;
            steps     <= '0;
            ray_ready <= 1'b0;
            state     <= STEP;
          end
        end
        STEP: begin
          query_pos   <= {march(origin[95:64], dir[95:64], t),
                          march(origin[63:32], dir[63:32], t),
                          march(origin[31:0],  dir[31:0],  t)};
          query_valid <= 1'b1;
          state       <= QUERY;
        end
        QUERY: begin
          steps <= steps + 8'd1;
`ifdef RAY_MARCH_TIMEOUT_EN
          wd    <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (dist_valid) begin
            res_pos   <= query_pos;
            res_depth <= t;
            res_steps <= steps;
            if (is_hit) begin
              res_hit   <= 1'b1;
              res_valid <= 1'b1;
              state     <= DONE;
            end else if (is_miss) begin
              res_hit   <= 1'b0;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              t     <= t_sum[31:0];
              state <= STEP;
            end
          end
`ifdef RAY_MARCH_TIMEOUT_EN
          else if (wd == 8'd254) begin
            res_pos   <= query_pos;
            res_depth <= t;
            res_steps <= steps;
            res_hit   <= 1'b0;
            timeout_q <= 1'b1;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            wd <= wd + 8'd1;
          end
`endif
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_hit   <= 1'b0;
`ifdef RAY_MARCH_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            ray_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
